decimal_entry: RTL and testbench
================================

// Module: decimal_entry
// PURPOSE
//  Decimal digit-entry accumulator. It does the reverse of the binary-to-7-segment
//  display path: BCD digits arrive one per strobe, most significant first, and are
//  built into a binary VALUE that can drive the display path directly.
//  Backspace removes the last digit using a sequential restoring divide-by-10.
//  Sits between keypad/switch debounce logic and the display/datapath.
// PARAMETERS
//  WIDTH       20  width of VALUE; must hold 10^MAX_DIGITS-1
//  MAX_DIGITS  6   maximum number of significant digits accepted
// PORTS
//  CLK          in   1      system clock, all logic on rising edge
//  RESET        in   1      synchronous, active-high reset
//  DIGIT        in   4      BCD digit to append (valid range 0..9)
//  DIGIT_VALID  in   1      append request, sampled only while READY=1
//  BACKSPACE    in   1      remove least significant digit, sampled only while READY=1
//  CLEAR        in   1      zero the entry; honoured in any state
//  VALUE        out  WIDTH  accumulated binary value
//  COUNT        out  3      number of significant digits held (0..MAX_DIGITS)
//  READY        out  1      1 = IDLE, commands accepted this cycle
//  ERR          out  1      one-cycle pulse: request rejected
// BEHAVIOUR
//  Reset: VALUE=0, COUNT=0, READY=1, ERR=0, state=IDLE. Reset aborts any division.
//  States: IDLE, DIV. Both commands and CLEAR are registered at the clock edge.
//  Priority in one cycle: RESET > CLEAR > BACKSPACE > DIGIT_VALID.
//  CLEAR: next cycle VALUE=0, COUNT=0, state=IDLE, ERR=0. CLEAR aborts DIV.
//  Append (IDLE, DIGIT_VALID=1, BACKSPACE=0, CLEAR=0):
//   - DIGIT>9: ERR=1 next cycle; VALUE and COUNT are unchanged.
//   - COUNT==MAX_DIGITS: ERR=1 next cycle; VALUE and COUNT are unchanged.
//   - Otherwise next cycle VALUE=(VALUE<<3)+(VALUE<<1)+DIGIT, computed at WIDTH bits.
//     COUNT increments, except when COUNT==0 and DIGIT==0 (no leading zeros;
//     VALUE stays 0 and COUNT stays 0).
//   - Latency is 1 cycle. READY stays 1, so back-to-back appends every cycle are legal.
//  Backspace (IDLE, BACKSPACE=1, CLEAR=0):
//   - COUNT==0: no-op. No ERR, READY stays 1.
//   - Otherwise, if accepted at edge t, the block enters DIV from t+1.
//     READY is 0 for exactly WIDTH cycles while it runs a restoring divide of
//     VALUE by 10, one quotient bit per cycle, MSB first.
//   - On the WIDTH-th DIV cycle's edge: VALUE=quotient, COUNT decrements, state=IDLE.
//     READY=1 from that cycle on.
//   - VALUE holds its old value throughout DIV. The remainder is discarded.
//   - DIGIT_VALID and BACKSPACE are ignored while READY=0: no queueing, no ERR.
//  ERR is high only in the cycle following a rejected append; otherwise 0.
//  No wrap-around is possible: MAX_DIGITS bounds VALUE below 2^WIDTH.
// TESTING
//  1) Reset, then digits 1,2,3 on consecutive cycles -> VALUE=123, COUNT=3, READY=1, ERR=0 throughout.
//  2) From 123, BACKSPACE pulse -> READY=0 for exactly 20 cycles, VALUE=123 during DIV;
//     then VALUE=12, COUNT=2, READY=1.
//  3) Seven digit-9 strobes -> VALUE=999999, COUNT=6; the 7th strobe gives a single ERR
//     pulse and VALUE is unchanged.
//  4) DIGIT=4'hA strobe with VALUE=45 -> ERR pulse 1 cycle, VALUE=45, COUNT=2.
//     Digits 0,0,7 from clear -> VALUE=7, COUNT=1.
//  5) CLEAR at DIV cycle 5 -> next cycle VALUE=0, COUNT=0, READY=1.
//     Digit strobe during DIV -> ignored, result is the plain quotient.
//  6) RESET at DIV cycle 10 -> next cycle all outputs at reset values.
//     BACKSPACE with COUNT=0 -> READY stays 1, no ERR.

Source files
------------

// File: rtl/decimal_entry_if.sv
// Decimal entry command/result bundle between the keypad front end and the accumulator.
// Latency: none, wires only.
// Backpressure: ready low means digit_valid and backspace are dropped, not held.
// Signals: digit/digit_valid/backspace/clear are commands into the accumulator;
// value/count/ready/err are its results. master = keypad side, slave = accumulator.
interface decimal_entry_if #(
    parameter int WIDTH = 20
);
    logic [3:0]       digit;
    logic             digit_valid;
    logic             backspace;
    logic             clear;
    logic [WIDTH-1:0] value;
    logic [2:0]       count;
    logic             ready;
    logic             err;

    modport master (
        output digit, digit_valid, backspace, clear,
        input  value, count, ready, err
    );

    modport slave (
        input  digit, digit_valid, backspace, clear,
        output value, count, ready, err
    );
endinterface

// File: rtl/decimal_entry.sv
// Decimal digit-entry accumulator: BCD digits MSB first build a binary value; backspace divides by 10.
// Latency: append 1 cycle; backspace WIDTH cycles of sequential restoring divide.
// Backpressure: ready low during the divide; digit_valid/backspace dropped then, clear always honoured.
// Ports: clk, reset (synchronous, active high); bus (slave) carries digit, digit_valid,
// backspace, clear in and value, count, ready, err out.
module decimal_entry #(
    parameter int WIDTH      = 20,
    parameter int MAX_DIGITS = 6
) (
    input  logic            clk,
    input  logic            reset,
    decimal_entry_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] value, value_n;
    logic [2:0]       count, count_n;
    logic             err, err_n;

    // Divider working registers: dvd shifts the dividend out MSB first,
    // quot collects quotient bits, rem is the partial remainder (always < 10).
    logic [WIDTH-1:0] dvd, dvd_n;
    logic [WIDTH-1:0] quot, quot_n;
    logic [3:0]       rem, rem_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic [4:0]       rem_sh;
    logic             ge;
    logic [WIDTH-1:0] quot_sh;
    logic [WIDTH-1:0] appended;

    always_comb begin
        // One restoring step: bring down the next dividend bit and subtract 10 if it fits.
        // The 4-bit subtraction is exact because the result is always below 10.
        rem_sh  = {rem, dvd[WIDTH-1]};
        ge      = (rem_sh >= 5'd10);
        quot_sh = {quot[WIDTH-2:0], ge};
        // value*10 + digit without a multiplier
        appended = (value << 3) + (value << 1) + {{(WIDTH-4){1'b0}}, bus.digit};
    end

    always_comb begin
        state_n = state;
        value_n = value;
        count_n = count;
        err_n   = 1'b0;
        dvd_n   = dvd;
        quot_n  = quot;
        rem_n   = rem;
        cnt_n   = cnt;

        if (bus.clear) begin
            state_n = IDLE;
            value_n = '0;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.backspace) begin
                        // Backspace on an empty entry is silently ignored.
                        if (count != 3'd0) begin
                            state_n = DIV;
                            dvd_n   = value;
                            quot_n  = '0;
                            rem_n   = '0;
                            cnt_n   = '0;
                        end
                    end else if (bus.digit_valid) begin
                        if ((bus.digit > 4'd9) || (count == 3'(MAX_DIGITS))) begin
                            err_n = 1'b1;
                        end else begin
                            value_n = appended;
                            // Leading zeros add nothing and are not counted.
                            if (!((count == 3'd0) && (bus.digit == 4'd0)))
                                count_n = count + 3'd1;
                        end
                    end
                end
                DIV: begin
                    rem_n  = ge ? (rem_sh[3:0] - 4'd10) : rem_sh[3:0];
                    quot_n = quot_sh;
                    dvd_n  = {dvd[WIDTH-2:0], 1'b0};
                    cnt_n  = cnt + CW'(1);
                    if (cnt == LAST) begin
                        value_n = quot_sh;
                        count_n = count - 3'd1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            value <= '0;
            count <= '0;
            err   <= 1'b0;
            dvd   <= '0;
            quot  <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            value <= value_n;
            count <= count_n;
            err   <= err_n;
            dvd   <= dvd_n;
            quot  <= quot_n;
            rem   <= rem_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.value = value;
    assign bus.count = count;
    assign bus.ready = (state == IDLE);
    assign bus.err   = err;
endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: appends, backspace divide timing, errors, clear/reset aborts.
module tb_decimal_entry;
    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    decimal_entry_if #(.WIDTH(20)) bus_i ();

    decimal_entry #(.WIDTH(20), .MAX_DIGITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] v, input logic [31:0] c,
                           input logic r, input logic e);
        chk({tag, ".value"}, 32'(bus_i.value), v);
        chk({tag, ".count"}, 32'(bus_i.count), c);
        chk({tag, ".ready"}, 32'(bus_i.ready), 32'(r));
        chk({tag, ".err"},   32'(bus_i.err),   32'(e));
    endtask

    // Called in the first DIV cycle; runs until ready returns (bounded), checks the
    // held value and absence of err each busy cycle, then the busy length.
    task automatic run_div(input string tag, input logic [31:0] hold, input int exp_cycles);
        int n = 0;
        while (!bus_i.ready && n < 100) begin
            chk({tag, ".hold"}, 32'(bus_i.value), hold);
            chk({tag, ".noerr"}, 32'(bus_i.err), 32'd0);
            tick();
            n++;
        end
        chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic put_digit(input logic [3:0] d);
        bus_i.digit = d;
        bus_i.digit_valid = 1'b1;
        tick();
        bus_i.digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus_i.clear = 1'b1;
        tick();
        bus_i.clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_i.digit = 4'd0;
        bus_i.digit_valid = 1'b0;
        bus_i.backspace = 1'b0;
        bus_i.clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_all("reset", 0, 0, 1'b1, 1'b0);

        // 1) back-to-back digits 1,2,3
        bus_i.digit_valid = 1'b1;
        bus_i.digit = 4'd1; tick(); chk_all("t1.d1", 1, 1, 1'b1, 1'b0);
        bus_i.digit = 4'd2; tick(); chk_all("t1.d2", 12, 2, 1'b1, 1'b0);
        bus_i.digit = 4'd3; tick(); chk_all("t1.d3", 123, 3, 1'b1, 1'b0);
        bus_i.digit_valid = 1'b0;

        // 2) backspace from 123
        bus_i.backspace = 1'b1; tick(); bus_i.backspace = 1'b0;
        run_div("t2", 123, 20);
        chk_all("t2.done", 12, 2, 1'b1, 1'b0);

        // 3) seven 9s: the seventh is rejected
        do_clear();
        chk_all("t3.clear", 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) put_digit(4'd9);
        chk_all("t3.six", 999999, 6, 1'b1, 1'b0);
        put_digit(4'd9);
        chk_all("t3.seventh", 999999, 6, 1'b1, 1'b1);
        tick();
        chk("t3.err_drop", 32'(bus_i.err), 32'd0);

        // 4) invalid BCD digit, then leading zeros
        do_clear();
        put_digit(4'd4);
        put_digit(4'd5);
        chk_all("t4.45", 45, 2, 1'b1, 1'b0);
        put_digit(4'hA);
        chk_all("t4.badbcd", 45, 2, 1'b1, 1'b1);
        tick();
        chk("t4.err_drop", 32'(bus_i.err), 32'd0);
        do_clear();
        put_digit(4'd0);
        chk_all("t4.z1", 0, 0, 1'b1, 1'b0);
        put_digit(4'd0);
        chk_all("t4.z2", 0, 0, 1'b1, 1'b0);
        put_digit(4'd7);
        chk_all("t4.7", 7, 1, 1'b1, 1'b0);

        // 5) clear at DIV cycle 5 aborts the divide
        do_clear();
        put_digit(4'd1);
        put_digit(4'd2);
        put_digit(4'd3);
        bus_i.backspace = 1'b1; tick(); bus_i.backspace = 1'b0;
        chk_all("t5.div1", 123, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("t5.div5_busy", 32'(bus_i.ready), 32'd0);
        do_clear();
        chk_all("t5.cleared", 0, 0, 1'b1, 1'b0);

        //    digit strobes during DIV are dropped
        put_digit(4'd4);
        put_digit(4'd5);
        put_digit(4'd6);
        bus_i.backspace = 1'b1; tick(); bus_i.backspace = 1'b0;
        bus_i.digit = 4'd9;
        bus_i.digit_valid = 1'b1;
        tick(); tick(); tick();
        bus_i.digit_valid = 1'b0;
        run_div("t5b", 456, 17);
        chk_all("t5b.done", 45, 2, 1'b1, 1'b0);

        // 6) backspace beats a simultaneous digit; reset at DIV cycle 10 aborts
        bus_i.backspace = 1'b1;
        bus_i.digit = 4'd3;
        bus_i.digit_valid = 1'b1;
        tick();
        bus_i.backspace = 1'b0;
        bus_i.digit_valid = 1'b0;
        chk_all("t6.div1", 45, 2, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        chk("t6.div10_busy", 32'(bus_i.ready), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all("t6.reset", 0, 0, 1'b1, 1'b0);

        //    backspace on an empty entry is a no-op
        bus_i.backspace = 1'b1; tick(); bus_i.backspace = 1'b0;
        chk_all("t6.bs_empty", 0, 0, 1'b1, 1'b0);
        tick();
        chk_all("t6.bs_empty2", 0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
